mem_master: RTL

Initiator-side controller for the single-port word memory: accepts read/write requests from the CPU datapath over valid/ready handshakes, drives the memory's `write`/`address`/`data_in` port and captures its combinational `data_out`. It sits between the load/store or fetch logic and the memory and serialises multi-word bursts. It is the only agent that drives the memory port.

---
 rtl/mem_master_pkg.sv | 14 +
 rtl/mem_addr_gen.sv | 48 ++++
 rtl/mem_master.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared types and default geometry for the memory initiator
package mem_master_pkg;

   localparam int DEF_WORD_SIZE = 32;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_LEN_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// rtl/mem_addr_gen.sv - burst address/beat counter; MEM_MASTER_BURST_EN builds the remaining count
module mem_addr_gen
   import mem_master_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              last
);

   // Address wraps naturally at 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (rst)
         cur_addr <= '0;
      else if (load)
         cur_addr <= load_addr;
      else if (step)
         cur_addr <= cur_addr + ADDR_W'(1);
   end

`ifdef MEM_MASTER_BURST_EN
   logic [LEN_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (rst)
         remaining <= '0;
      else if (load)
         remaining <= load_len;
      else if (step)
         remaining <= remaining - LEN_W'(1);
   end

   assign last = (remaining == '0);
`else
   // Single-word requests only: the length field is dropped.
   logic unused_len;
   assign unused_len = ^load_len;
   assign last       = 1'b1;
`endif

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - initiator driving the single-port word memory; bursts enabled by MEM_MASTER_BURST_EN
module mem_master
   import mem_master_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int LEN_W     = DEF_LEN_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [LEN_W-1:0]     req_len,
   input  logic                 wd_valid,
   output logic                 wd_ready,
   input  logic [WORD_SIZE-1:0] wd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [WORD_SIZE-1:0] rd_data,
   output logic                 rd_last,
   output logic                 wr_done,
   output logic                 mem_write,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [WORD_SIZE-1:0] mem_data_in,
   input  logic [WORD_SIZE-1:0] mem_data_out
);

   state_t              state, next_state;
   logic                load, step, capture, wr_beat, last;
   logic [ADDR_W-1:0]   cur_addr;

   mem_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .load_addr (req_addr),
      .load_len  (req_len),
      .cur_addr  (cur_addr),
      .last      (last)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      wd_ready   = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      capture    = 1'b0;
      wr_beat    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               load       = 1'b1;
               next_state = req_write ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            // Capture only when the output register is free or being drained.
            if (!rd_valid || rd_ready) begin
               capture = 1'b1;
               step    = 1'b1;
               if (last)
                  next_state = ST_IDLE;
            end
         end
         ST_WR: begin
            wd_ready = 1'b1;
            if (wd_valid) begin
               wr_beat = 1'b1;
               step    = 1'b1;
               if (last)
                  next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign mem_write   = wr_beat && !rst;
   assign mem_address = cur_addr;
   assign mem_data_in = mem_write ? wd_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
      end else begin
         wr_done <= wr_beat && last;
         if (capture) begin
            rd_data  <= mem_data_out;
            rd_valid <= 1'b1;
            rd_last  <= last;
         end else if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end
      end
   end

endmodule
